// File: rtl/pipe_pkg.sv
// Shared types and encodings for the forwarding / hazard scoreboard.
package pipe_pkg;

  // Widest register specifier a scoreboard entry can carry.
  // Narrower specifiers are zero-extended into it.
  localparam int unsigned SB_REG_W = 8;

  // Bypass select encoding: 0 reads the register file, k reads stage k.
  localparam int unsigned FWD_RF = 0;

  localparam logic [SB_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rs;
    logic [SB_REG_W-1:0] rt;
    logic                uses_rs;
    logic                uses_rt;
    logic [SB_REG_W-1:0] rd;
    logic                wr;
    logic                ld;
    logic                st;
  } sb_entry_t;

  // Select value for producer stage k.
  function automatic int unsigned FWD_STAGE(input int unsigned k);
    return k;
  endfunction

  // A live, register-writing entry whose non-zero destination equals s.
  function automatic logic prod_match(input sb_entry_t p, input logic [SB_REG_W-1:0] s);
    return p.valid && p.wr && (p.rd != REG_ZERO) && (p.rd == s);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment only while below the saturation value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Scoreboard-driven bypass select, stall and bubble generation beside ID.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W    = 4,
  parameter  int unsigned BYPASS_STAGES = 2,
  parameter  int unsigned CNT_W         = 16,
  localparam int unsigned SEL_W         = $clog2(BYPASS_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_write_reg,
  input  logic                  id_is_load,
  input  logic                  id_is_store,
  input  logic                  id_is_branch,
  input  logic                  flush,
  input  logic                  hold,
  output logic [SEL_W-1:0]      fwd_a,
  output logic [SEL_W-1:0]      fwd_b,
  output logic                  fwd_mem,
  output logic                  fwd_branch,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      br_stall_cnt
);

  // slot 0 is EX, slots 1..BYPASS_STAGES are the forwarding producers
  sb_entry_t slot_q [BYPASS_STAGES+1];
  sb_entry_t slot_d [BYPASS_STAGES+1];

  sb_entry_t           id_entry;
  logic [SB_REG_W-1:0] id_rs_x;
  logic [SB_REG_W-1:0] id_rt_x;
  logic                lu_hazard;
  logic                br_hazard;
  logic                br_young_hit;
  logic                br_last_hit;
  logic                lu_inc;
  logic                br_inc;

  // Decode-time fields packed into a scoreboard entry; a flush kills it.
  always_comb begin
    id_rs_x          = SB_REG_W'(id_rs);
    id_rt_x          = SB_REG_W'(id_rt);
    id_entry         = '0;
    id_entry.valid   = id_valid & ~flush;
    id_entry.rs      = id_rs_x;
    id_entry.rt      = id_rt_x;
    id_entry.uses_rs = id_uses_rs;
    id_entry.uses_rt = id_uses_rt;
    id_entry.rd      = SB_REG_W'(id_rd);
    id_entry.wr      = id_write_reg;
    id_entry.ld      = id_is_load;
    id_entry.st      = id_is_store;
  end

  // EX operand bypass: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_a = SEL_W'(FWD_RF);
    fwd_b = SEL_W'(FWD_RF);
    for (int k = int'(BYPASS_STAGES); k >= 1; k--) begin
      if (slot_q[0].uses_rs && prod_match(slot_q[k], slot_q[0].rs)) begin
        fwd_a = SEL_W'(FWD_STAGE(unsigned'(k)));
      end
      if (slot_q[0].uses_rt && prod_match(slot_q[k], slot_q[0].rt)) begin
        fwd_b = SEL_W'(FWD_STAGE(unsigned'(k)));
      end
    end
  end

  // Store data in MEM picked up from the oldest stage's writeback value.
  always_comb begin
    fwd_mem = slot_q[1].st && prod_match(slot_q[BYPASS_STAGES], slot_q[1].rt);
  end

  // Load-use: a store's data operand is bypassed in MEM, so it alone never stalls.
  always_comb begin
    lu_hazard = 1'b0;
    if (slot_q[0].valid && slot_q[0].ld && slot_q[0].wr && (slot_q[0].rd != REG_ZERO)) begin
      lu_hazard = (id_uses_rs && (slot_q[0].rd == id_rs_x)) ||
                  (id_uses_rt && (slot_q[0].rd == id_rt_x) && !id_is_store);
    end
  end

  // Branch resolved in ID: stall until the producer reaches the last stage.
  always_comb begin
    br_young_hit = 1'b0;
    for (int k = 0; k < int'(BYPASS_STAGES); k++) begin
      if (prod_match(slot_q[k], id_rs_x)) begin
        br_young_hit = 1'b1;
      end
    end
    br_last_hit = prod_match(slot_q[BYPASS_STAGES], id_rs_x);
    br_hazard   = id_is_branch && id_valid && br_young_hit;
    fwd_branch  = id_is_branch && !br_young_hit && br_last_hit;
  end

  // Stall/bubble and counter increments; a frozen pipeline neither stalls nor counts.
  always_comb begin
    stall_id  = (lu_hazard || br_hazard) && id_valid && !hold;
    bubble_ex = stall_id;
    lu_inc    = lu_hazard && id_valid && !hold;
    br_inc    = br_hazard && !lu_hazard && id_valid && !hold;
  end

  // Scoreboard advance: shift producers, load EX from ID or a bubble.
  always_comb begin
    slot_d = slot_q;
    if (!hold) begin
      for (int i = int'(BYPASS_STAGES); i >= 1; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = stall_id ? sb_entry_t'('0) : id_entry;
    end
  end

  // Scoreboard register with synchronous reset to all-invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= int'(BYPASS_STAGES); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_inc),
    .count (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc),
    .count (br_stall_cnt)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a second narrow-counter instance shows saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [3:0] id_rd;
  logic       id_write_reg;
  logic       id_is_load;
  logic       id_is_store;
  logic       id_is_branch;
  logic       flush;
  logic       hold;

  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        fwd_mem;
  logic        fwd_branch;
  logic        stall_id;
  logic        bubble_ex;
  logic [15:0] lu_stall_cnt;
  logic [15:0] br_stall_cnt;

  logic [1:0]  s_fwd_a;
  logic [1:0]  s_fwd_b;
  logic        s_fwd_mem;
  logic        s_fwd_branch;
  logic        s_stall_id;
  logic        s_bubble_ex;
  logic [3:0]  s_lu_stall_cnt;
  logic [3:0]  s_br_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(4), .BYPASS_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_write_reg(id_write_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_is_branch(id_is_branch), .flush(flush), .hold(hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem), .fwd_branch(fwd_branch),
    .stall_id(stall_id), .bubble_ex(bubble_ex),
    .lu_stall_cnt(lu_stall_cnt), .br_stall_cnt(br_stall_cnt)
  );

  fwd_hazard_unit #(.REG_ADDR_W(4), .BYPASS_STAGES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_write_reg(id_write_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_is_branch(id_is_branch), .flush(flush), .hold(hold),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_mem(s_fwd_mem), .fwd_branch(s_fwd_branch),
    .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
    .lu_stall_cnt(s_lu_stall_cnt), .br_stall_cnt(s_br_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic urs, input logic urt, input logic [3:0] rd,
                        input logic wr, input logic ld, input logic st, input logic br);
    id_valid = v;   id_rs = rs;       id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; id_rd = rd;
    id_write_reg = wr; id_is_load = ld; id_is_store = st; id_is_branch = br;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_op(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw_op(input logic [3:0] rd, input logic [3:0] rs);
    set_id(1'b1, rs, 4'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    idle();
    step(); step();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_fwd_mem", 32'(fwd_mem), 0);
    chk("rst_fwd_branch", 32'(fwd_branch), 0);
    chk("rst_stall", 32'(stall_id), 0);
    chk("rst_bubble", 32'(bubble_ex), 0);
    chk("rst_lu_cnt", 32'(lu_stall_cnt), 0);
    chk("rst_br_cnt", 32'(br_stall_cnt), 0);

    // 1: ADD r3 ; ADD r4,r3,r3
    add_op(4'd3, 4'd1, 4'd2); step();
    add_op(4'd4, 4'd3, 4'd3); #1;
    chk("t1_no_stall", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t1_fwd_a", 32'(fwd_a), 1);
    chk("t1_fwd_b", 32'(fwd_b), 1);
    drain();

    // 2: ADD r3 ; ADD r8 ; SUB r5,r3,r1
    add_op(4'd3, 4'd1, 4'd2); step();
    add_op(4'd8, 4'd1, 4'd2); step();
    add_op(4'd5, 4'd3, 4'd1); #1;
    chk("t2_no_stall", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t2_fwd_a", 32'(fwd_a), 2);
    chk("t2_fwd_b", 32'(fwd_b), 0);
    drain();

    // 3: two producers of r3, youngest wins
    add_op(4'd3, 4'd1, 4'd2); step();
    add_op(4'd3, 4'd1, 4'd2); step();
    add_op(4'd7, 4'd3, 4'd0); step();
    idle(); #1;
    chk("t3_fwd_a_youngest", 32'(fwd_a), 1);
    chk("t3_fwd_b_r0", 32'(fwd_b), 0);
    drain();

    // 4: LW r2 ; ADD r6,r2,r1 -> one load-use stall
    lw_op(4'd2, 4'd1); step();
    add_op(4'd6, 4'd2, 4'd1); #1;
    chk("t4_stall", 32'(stall_id), 1);
    chk("t4_bubble", 32'(bubble_ex), 1);
    chk("t4_lu_cnt_before", 32'(lu_stall_cnt), 0);
    step();
    chk("t4_stall_released", 32'(stall_id), 0);
    chk("t4_lu_cnt_after", 32'(lu_stall_cnt), 1);
    step(); idle(); #1;
    chk("t4_fwd_a", 32'(fwd_a), 2);
    chk("t4_fwd_b", 32'(fwd_b), 0);
    drain();

    // 5: LW r2 ; SW r2,0(r7) -> no stall, store data bypassed in MEM
    lw_op(4'd2, 4'd1); step();
    set_id(1'b1, 4'd7, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    chk("t5_no_stall", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t5_fwd_b_ex", 32'(fwd_b), 1);
    chk("t5_fwd_mem_early", 32'(fwd_mem), 0);
    step();
    chk("t5_fwd_mem", 32'(fwd_mem), 1);
    chk("t5_lu_cnt", 32'(lu_stall_cnt), 1);
    drain();

    // 6a: load into r0 never stalls nor forwards
    lw_op(4'd0, 4'd1); step();
    add_op(4'd4, 4'd0, 4'd0); #1;
    chk("t6a_no_stall", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t6a_fwd_a", 32'(fwd_a), 0);
    chk("t6a_fwd_b", 32'(fwd_b), 0);
    drain();

    // 6b: flush-killed load
    lw_op(4'd2, 4'd1); flush = 1'b1; step();
    flush = 1'b0;
    add_op(4'd4, 4'd2, 4'd2); #1;
    chk("t6b_no_stall", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t6b_fwd_a", 32'(fwd_a), 0);
    chk("t6b_fwd_b", 32'(fwd_b), 0);
    drain();

    // 6c: hold for 3 cycles during a load-use stall
    lw_op(4'd2, 4'd1); step();
    add_op(4'd6, 4'd2, 4'd1); #1;
    chk("t6c_stall_pre", 32'(stall_id), 1);
    hold = 1'b1; #1;
    chk("t6c_hold_stall", 32'(stall_id), 0);
    chk("t6c_hold_bubble", 32'(bubble_ex), 0);
    chk("t6c_hold_fwd_a", 32'(fwd_a), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6c_hold_lu_cnt", 32'(lu_stall_cnt), 1);
      chk("t6c_hold_stall_cyc", 32'(stall_id), 0);
    end
    hold = 1'b0; #1;
    chk("t6c_stall_resumed", 32'(stall_id), 1);
    step();
    chk("t6c_lu_cnt", 32'(lu_stall_cnt), 2);
    chk("t6c_stall_released", 32'(stall_id), 0);
    step(); idle(); #1;
    chk("t6c_fwd_a", 32'(fwd_a), 2);
    drain();

    // Branch on r9 after ADD r9: two stall cycles then last-stage bypass
    add_op(4'd9, 4'd1, 4'd2); step();
    set_id(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("br_stall_1", 32'(stall_id), 1);
    chk("br_no_fwd_1", 32'(fwd_branch), 0);
    step();
    chk("br_stall_2", 32'(stall_id), 1);
    chk("br_cnt_1", 32'(br_stall_cnt), 1);
    step();
    chk("br_go", 32'(stall_id), 0);
    chk("br_fwd", 32'(fwd_branch), 1);
    chk("br_cnt_2", 32'(br_stall_cnt), 2);
    drain();

    // LW r9 then branch on r9: the overlap cycle counts only as load-use
    lw_op(4'd9, 4'd1); step();
    set_id(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("lubr_stall_1", 32'(stall_id), 1);
    step();
    chk("lubr_stall_2", 32'(stall_id), 1);
    chk("lubr_lu_cnt", 32'(lu_stall_cnt), 3);
    chk("lubr_br_cnt_mid", 32'(br_stall_cnt), 2);
    step();
    chk("lubr_go", 32'(stall_id), 0);
    chk("lubr_fwd", 32'(fwd_branch), 1);
    chk("lubr_br_cnt", 32'(br_stall_cnt), 3);
    drain();

    // Self-dependent branch repeated: 2 stall cycles per 3, drives the narrow counter to all-ones
    set_id(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 31; i++) begin
      step();
    end
    idle(); #1;
    chk("sat_main_br_cnt", 32'(br_stall_cnt), 23);
    chk("sat_narrow_br_cnt", 32'(s_br_stall_cnt), 15);
    chk("sat_narrow_lu_cnt", 32'(s_lu_stall_cnt), 3);
    step();
    chk("sat_narrow_br_hold", 32'(s_br_stall_cnt), 15);
    drain();

    // Reset in the middle of a load-use stall
    lw_op(4'd2, 4'd1); step();
    add_op(4'd6, 4'd2, 4'd1); #1;
    chk("rstmid_stall_pre", 32'(stall_id), 1);
    rst = 1'b1; step();
    rst = 1'b0; #1;
    chk("rstmid_stall", 32'(stall_id), 0);
    chk("rstmid_bubble", 32'(bubble_ex), 0);
    chk("rstmid_lu_cnt", 32'(lu_stall_cnt), 0);
    chk("rstmid_br_cnt", 32'(br_stall_cnt), 0);
    chk("rstmid_fwd_a", 32'(fwd_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational forwarding logic, for the 5-stage WISC pipeline.
- Keeps an internal scoreboard of in-flight instructions, a shift pipeline that mirrors ID/EX, EX/MEM, MEM/WB and any deeper stages.
- From that scoreboard it generates ALU, memory and branch bypass selects, load-use and branch stalls, bubble insertion and saturating stall counters.
- Sits beside the ID stage and is fed only decode-time fields.

Parameters:
REG_ADDR_W, 4, register-specifier width; register 0 is hardwired zero.
BYPASS_STAGES, 2, producer stages after EX that can forward (min 2); stage k = k-th register after EX.
CNT_W, 16, width of the saturating stall counters.
SEL_W, $clog2(BYPASS_STAGES+1), localparam; bypass select width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  source A specifier
id_rt  in  REG_ADDR_W  source B specifier
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  REG_ADDR_W  destination specifier
id_write_reg  in  1  instruction writes rd
id_is_load  in  1  LW
id_is_store  in  1  SW (rt = store data)
id_is_branch  in  1  branch resolved in ID using rs
flush  in  1  kill the instruction leaving ID this cycle
hold  in  1  global freeze (memory not ready)
fwd_a  out  SEL_W  EX operand A select: 0 = regfile, k = stage k
fwd_b  out  SEL_W  EX operand B select
fwd_mem  out  1  store data in MEM taken from the last stage's writeback value
fwd_branch  out  1  ID branch rs taken from the last stage's writeback value
stall_id  out  1  hold PC and IF/ID
bubble_ex  out  1  insert NOP into ID/EX
lu_stall_cnt  out  CNT_W  load-use stall cycles
br_stall_cnt  out  CNT_W  branch stall cycles

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst.
- Scoreboard: slot[0] = EX, slot[1..BYPASS_STAGES] = producers. Each entry holds {valid, rs, rt, uses_rs, uses_rt, rd, wr, ld, st}.
- Normal advance: each posedge with rst=0, hold=0, stall_id=0:
  - slot[i+1] <= slot[i].
  - slot[0] <= ID fields, with valid = id_valid & ~flush.
- Stall advance: with stall_id=1, slot[0] <= bubble (valid=0) and upper slots still shift. flush is ignored while stall_id=1.
- hold=1: no slot changes and counters do not increment. Outputs stay combinationally valid from the current slots.
- A producer in slot[k] matches a source s when all of these hold: valid, wr, rd != 0, rd == s.
- fwd_a: the smallest k in 1..BYPASS_STAGES matching slot[0].rs with slot[0].uses_rs, else 0. Youngest producer wins. fwd_b is the same for rt.
- fwd_mem: slot[1].st and slot[BYPASS_STAGES] matches slot[1].rt.
- Load-use stall: slot[0] is ld+wr with rd != 0 and equal to an ID source that is used. Exception: the only match is id_rt of a store, with id_uses_rs not matching; this is covered by fwd_mem and does not stall.
- Branch stall: id_is_branch & id_valid and id_rs matches any slot[0..BYPASS_STAGES-1].
- fwd_branch: id_is_branch and the first match is slot[BYPASS_STAGES].
- stall_id = bubble_ex = (load-use | branch stall) & id_valid & ~hold. All outputs are combinational from slots and ID inputs, so there is zero latency.
- Counters: lu_stall_cnt increments on a load-use stall cycle. br_stall_cnt increments on a branch stall cycle that is not also load-use, so a cycle with both counts only in lu_stall_cnt. Both saturate at all-ones with no wrap.
- Reset: all slots invalid and counters 0. Reset therefore forces fwd_a = fwd_b = 0 and fwd_mem = fwd_branch = stall_id = bubble_ex = 0. Reset mid-stall clears the stall on the next cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - the scoreboard entry struct sb_entry_t;
  - the select encoding constants FWD_RF = 0 and FWD_STAGE(k) = k;
  - REG_ZERO.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice.

Test Plan:
1. ADD r3 then ADD r4,r3,r3 back-to-back -> fwd_a = fwd_b = 1, no stall.
2. ADD r3; unrelated; SUB r5,r3,r1 -> fwd_a = 2.
3. Producers of r3 in both slot[1] and slot[2] -> fwd_a = 1 (youngest wins).
4. LW r2 then ADD r6,r2,r1:
   - Cycle 1: stall_id = bubble_ex = 1.
   - Next cycle: fwd_a = 2.
   - lu_stall_cnt: 0 -> 1.
5. LW r2 then SW r2,0(r7) -> no stall, fwd_mem = 1 when the SW is in MEM.
6. Each of these -> all selects 0, no stall:
   - dest r0;
   - flush-killed producer;
   - hold=1 asserted for 3 cycles mid-stall (counter frozen, slots unchanged).
   
   Also force the counter to 0xFFFF with a branch stall -> it stays at 0xFFFF.
